// File: rtl/mux2_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux2_arb_pkg
// Shared definitions for the two-input merging arbiter.
//   WIDTH_DEFAULT : default payload width of every channel
//   src_idx_t     : 1-bit source index used by out_sel, grant and last_grant
//   SRC0 / SRC1   : named source indices
// -----------------------------------------------------------------------------
package mux2_arb_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef logic src_idx_t;

  localparam src_idx_t SRC0 = 1'b0;
  localparam src_idx_t SRC1 = 1'b1;

endpackage : mux2_arb_pkg

// File: rtl/mux2_arb_if.sv
// -----------------------------------------------------------------------------
// mux2_arb_if
// Bundles the two input channels and the merged output channel.
//   in0_valid/in0_ready/in0_data : source 0 handshake and payload
//   in1_valid/in1_ready/in1_data : source 1 handshake and payload
//   out_valid/out_ready/out_data : merged output handshake and payload
//   out_sel                      : which source produced out_data
// Modports:
//   slave  : the arbiter (receives input words, drives the output channel)
//   master : the environment (drives sources, consumes the output)
// -----------------------------------------------------------------------------
interface mux2_arb_if
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in0_data;

  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in1_data;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  src_idx_t         out_sel;

  modport slave (
    input  in0_valid, in0_data,
    input  in1_valid, in1_data,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_data, out_sel
  );

  modport master (
    output in0_valid, in0_data,
    output in1_valid, in1_data,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_data, out_sel
  );

endinterface : mux2_arb_if

// File: rtl/mux2_arb_sel.sv
// -----------------------------------------------------------------------------
// mux2_arb_sel
// Purely combinational grant logic for the two-input arbiter.
//   in0_valid_i  : source 0 requests
//   in1_valid_i  : source 1 requests
//   last_grant_i : source granted on the most recent accepted transfer
//   load_i       : output register can take a word this cycle
//   grant_o      : winning source index (meaningful only with grant_en_o)
//   grant_en_o   : a transfer is granted this cycle
// Build option:
//   MUX2_ARB_RR_EN defined   -> ties alternate (round-robin on last_grant_i)
//   MUX2_ARB_RR_EN undefined -> ties always go to source 0
// -----------------------------------------------------------------------------
module mux2_arb_sel
  import mux2_arb_pkg::*;
(
  input  logic     in0_valid_i,
  input  logic     in1_valid_i,
  input  src_idx_t last_grant_i,
  input  logic     load_i,
  output src_idx_t grant_o,
  output logic     grant_en_o
);

  src_idx_t tie_grant;

`ifdef MUX2_ARB_RR_EN
  // Reset leaves last_grant at source 1, so the first tie goes to source 0.
  assign tie_grant = ~last_grant_i;
`else
  // Fixed priority: last_grant is still tracked by the top but plays no role.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign tie_grant         = SRC0;
`endif

  always_comb begin
    grant_o = SRC0;
    if (in0_valid_i && in1_valid_i) begin
      grant_o = tie_grant;
    end else if (in1_valid_i) begin
      grant_o = SRC1;
    end
  end

  assign grant_en_o = load_i && (in0_valid_i || in1_valid_i);

endmodule : mux2_arb_sel

// File: rtl/mux2_arb.sv
// -----------------------------------------------------------------------------
// mux2_arb
// Merges two valid/ready sources into one registered output channel.
// A granted input word appears on the output one cycle after acceptance;
// the output register can drain and reload in the same cycle, giving one
// word per cycle when the sink keeps out_ready high.
//   clk   : single clock, rising edge
//   rst_n : asynchronous, active-low reset
//   bus   : mux2_arb_if.slave -- both input channels and the output channel
// Build option: MUX2_ARB_RR_EN (see mux2_arb_sel) selects the tie policy.
// -----------------------------------------------------------------------------
module mux2_arb
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
)(
  input  logic     clk,
  input  logic     rst_n,
  mux2_arb_if.slave bus
);

  logic             load;
  src_idx_t         grant;
  logic             grant_en;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  src_idx_t         out_sel_q,   out_sel_d;
  src_idx_t         last_grant_q, last_grant_d;

  // The output register is free when empty or being drained this cycle.
  assign load = !out_valid_q || bus.out_ready;

  mux2_arb_sel u_sel (
    .in0_valid_i  (bus.in0_valid),
    .in1_valid_i  (bus.in1_valid),
    .last_grant_i (last_grant_q),
    .load_i       (load),
    .grant_o      (grant),
    .grant_en_o   (grant_en)
  );

  // The register is empty in reset, so load is high; gating with rst_n keeps
  // both readys low so no source believes a word was taken during reset.
  assign accept        = grant_en && rst_n;
  assign bus.in0_ready = accept && (grant == SRC0);
  assign bus.in1_ready = accept && (grant == SRC1);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (grant_en) begin
      out_valid_d  = 1'b1;
      out_data_d   = (grant == SRC1) ? bus.in1_data : bus.in0_data;
      out_sel_d    = grant;
      last_grant_d = grant;
    end else if (bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= SRC0;
      last_grant_q <= SRC1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule : mux2_arb

// File: tb/tb_mux2_arb.sv
// -----------------------------------------------------------------------------
// tb_mux2_arb
// Directed stimulus with hand-computed expectations, plus a per-cycle
// behavioural model of the arbiter's observable rules (one held word, one
// remembered winner) compared against the DUT on every falling edge.
// Inputs change 1 time unit after the rising edge; the model samples on the
// falling edge when inputs and outputs are both stable.
// -----------------------------------------------------------------------------
module tb_mux2_arb;

  localparam int W = 8;

`ifdef MUX2_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst_n;

  mux2_arb_if #(.WIDTH(W)) bus ();

  mux2_arb #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: what word the output must hold and who won last.
  // ---------------------------------------------------------------------------
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sel;
  logic       m_last;

  initial begin
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 1'b0;
    m_last  = 1'b1;
    forever begin
      logic room, winner, e0, e1;
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 1'b0;
        m_last  = 1'b1;
      end
      chk("mdl out_valid", bus.out_valid, m_valid);
      if (m_valid || !rst_n) begin
        chk("mdl out_data", bus.out_data, m_data);
        chk("mdl out_sel",  bus.out_sel,  m_sel);
      end
      room   = !m_valid || bus.out_ready;
      winner = 1'b0;
      e0     = 1'b0;
      e1     = 1'b0;
      if (rst_n && room && (bus.in0_valid || bus.in1_valid)) begin
        if (bus.in0_valid && bus.in1_valid) winner = RR ? !m_last : 1'b0;
        else                                winner = bus.in1_valid;
        e0 = (winner == 1'b0);
        e1 = (winner == 1'b1);
      end
      chk("mdl in0_ready", bus.in0_ready, e0);
      chk("mdl in1_ready", bus.in1_ready, e1);
      if (rst_n) begin
        if (e0 || e1) begin
          m_valid = 1'b1;
          m_data  = winner ? bus.in1_data : bus.in0_data;
          m_sel   = winner;
          m_last  = winner;
        end else if (bus.out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic apply(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic ordy);
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, " out_valid"}, bus.out_valid, v);
    chk({tag, " out_data"},  bus.out_data,  d);
    chk({tag, " out_sel"},   bus.out_sel,   s);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, " in0_ready"}, bus.in0_ready, r0);
    chk({tag, " in1_ready"}, bus.in1_ready, r1);
  endtask

  initial begin
    logic [7:0] n0, n1;
    logic       g;

    // Reset with a request pending: outputs clear, readys stay low.
    rst_n = 1'b0;
    apply(1'b1, 8'h77, 1'b1, 8'h78, 1'b1);
    #1;
    chk_out("reset", 1'b0, 8'h00, 1'b0);
    chk_rdy("reset", 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single source 1, back-to-back words, then drain.
    apply(1'b0, 8'h00, 1'b1, 8'h11, 1'b1);
    chk_rdy("s1 w0", 1'b0, 1'b1);
    tick();
    chk_out("s1 w0", 1'b1, 8'h11, 1'b1);
    apply(1'b0, 8'h00, 1'b1, 8'h22, 1'b1);
    chk_rdy("s1 w1", 1'b0, 1'b1);
    tick();
    chk_out("s1 w1", 1'b1, 8'h22, 1'b1);
    apply(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
    tick();
    chk_out("s1 w2", 1'b1, 8'h33, 1'b1);
    apply(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk_rdy("drain", 1'b0, 1'b0);
    tick();
    chk("drain out_valid", bus.out_valid, 1'b0);

    // Backpressure: word 0x5C held for three stalled cycles.
    apply(1'b1, 8'h5C, 1'b0, 8'h00, 1'b0);
    chk_rdy("bp load", 1'b1, 1'b0);
    tick();
    chk_out("bp load", 1'b1, 8'h5C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 8'h5D, 1'b1, 8'h6E, 1'b0);
      chk_rdy("bp stall", 1'b0, 1'b0);
      tick();
      chk_out("bp stall", 1'b1, 8'h5C, 1'b0);
    end
    // Release: drain and reload in the same cycle; last winner was source 0.
    apply(1'b1, 8'h5D, 1'b1, 8'h6E, 1'b1);
    if (RR) chk_rdy("bp release", 1'b0, 1'b1);
    else    chk_rdy("bp release", 1'b1, 1'b0);
    tick();
    if (RR) chk_out("bp release", 1'b1, 8'h6E, 1'b1);
    else    chk_out("bp release", 1'b1, 8'h5D, 1'b0);

    // Mid-stream reset while a word is held under backpressure.
    apply(1'b1, 8'h5D, 1'b1, 8'h6E, 1'b0);
    chk_rdy("pre-reset", 1'b0, 1'b0);
    tick();
    chk("pre-reset out_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_out("mid reset", 1'b0, 8'h00, 1'b0);
    chk_rdy("mid reset", 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Tie: both sources valid every cycle, first tie after reset.
    n0 = 8'hA0;
    n1 = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] iv;
      iv = i;
      g  = RR ? iv[0] : 1'b0;
      apply(1'b1, n0, 1'b1, n1, 1'b1);
      chk_rdy("tie", !g, g);
      tick();
      chk_out("tie", 1'b1, g ? n1 : n0, g);
      if (g) n1 = n1 + 8'h01;
      else   n0 = n0 + 8'h01;
    end

    // Final drain.
    apply(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    chk("final drain out_valid", bus.out_valid, 1'b0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mux2_arb
